// File: rtl/noc_pkg.sv
// Shared types for the noc_router receive node: packet layout, class encoding and FSM states.
// Optional address filtering is enabled with the ADDR_FILTER_EN macro (see noc_router).
package noc_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int ADDR_W_DEF  = 2;
  localparam int PTYPE_W     = 2;
  localparam int NUM_CLASSES = 4;
  localparam int PKT_W_DEF   = 1 + DATA_W_DEF + PTYPE_W + ADDR_W_DEF;
  localparam int DROP_W      = 8;

  typedef enum logic [PTYPE_W-1:0] {
    DATA = 2'b00,
    CTRL = 2'b01,
    RESP = 2'b10,
    RSVD = 2'b11
  } pkt_type_e;

  typedef struct packed {
    logic                  hdr_valid;
    logic [DATA_W_DEF-1:0] payload;
    pkt_type_e             ptype;
    logic [ADDR_W_DEF-1:0] addr;
  } noc_packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ROUTE   = 2'b01,
    DELIVER = 2'b10
  } noc_state_e;

endpackage

// File: rtl/noc_buffer_bank.sv
// Four persistent per-class payload registers; one write per accepted packet,
// steered by the packet type. Asynchronous active-low reset clears all classes.
module noc_buffer_bank
  import noc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  pkt_type_e         sel_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic [DATA_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] resp_o,
  output logic [DATA_W-1:0] rsvd_o
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_buf
      logic [DATA_W-1:0] buf_q;
      logic              hit;

      // class index gi matches the pkt_type_e encoding of that class
      assign hit = wr_en_i && (sel_i == pkt_type_e'(PTYPE_W'(gi)));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          buf_q <= '0;
        end else if (hit) begin
          buf_q <= wdata_i;
        end
      end
    end
  endgenerate

  assign data_o = g_buf[0].buf_q;
  assign ctrl_o = g_buf[1].buf_q;
  assign resp_o = g_buf[2].buf_q;
  assign rsvd_o = g_buf[3].buf_q;

endmodule

// File: rtl/noc_router.sv
// Single-node NoC receive router: IDLE/ROUTE/DELIVER handshake FSM feeding a per-class buffer bank.
// Define ADDR_FILTER_EN to drop packets not addressed to NODE_ADDR and expose drop_count.
module noc_router
  import noc_pkg::*;
#(
  parameter int                DATA_W    = DATA_W_DEF,
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] NODE_ADDR = '0,
  localparam int               PKT_W     = 1 + DATA_W + PTYPE_W + ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PKT_W-1:0]  packet,
  input  logic              pack_valid,
  output logic              nocr_ready,
  output logic              nocr_valid,
  input  logic              pack_gen_ready,
  output logic [DATA_W-1:0] data_buffer,
  output logic [DATA_W-1:0] control_buffer,
  output logic [DATA_W-1:0] response_buffer,
  output logic [DATA_W-1:0] reserve_buffer
`ifdef ADDR_FILTER_EN
  ,
  output logic [DROP_W-1:0] drop_count
`endif
);

  noc_state_e        state_q;
  logic [PKT_W-1:0]  pkt_q;

  logic              hdr_q;
  logic [DATA_W-1:0] payload_q;
  pkt_type_e         ptype_q;
  logic [ADDR_W-1:0] addr_q;
  logic              addr_ok;
  logic              deliver_ok;
  logic              wr_en;

  assign hdr_q     = pkt_q[PKT_W-1];
  assign payload_q = pkt_q[PKT_W-2 -: DATA_W];
  assign ptype_q   = pkt_type_e'(pkt_q[ADDR_W +: PTYPE_W]);
  assign addr_q    = pkt_q[ADDR_W-1:0];

  assign deliver_ok = hdr_q && addr_ok;
  assign wr_en      = (state_q == ROUTE) && deliver_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pack_valid) begin
            pkt_q   <= packet;
            state_q <= ROUTE;
          end
        end
        ROUTE: begin
          state_q <= deliver_ok ? DELIVER : IDLE;
        end
        DELIVER: begin
          if (pack_gen_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ready is gated by reset so it reads low for the whole time reset is held
  assign nocr_ready = reset && (state_q == IDLE);
  assign nocr_valid = (state_q == DELIVER);

`ifdef ADDR_FILTER_EN
  logic [DROP_W-1:0] drop_q;
  logic [DROP_W-1:0] drop_d;

  assign addr_ok = (addr_q == NODE_ADDR);

  always_comb begin
    drop_d = drop_q;
    if ((state_q == ROUTE) && !deliver_ok && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`else
  logic unused_addr;

  assign addr_ok     = 1'b1;
  assign unused_addr = ^{addr_q, NODE_ADDR};
`endif

  noc_buffer_bank #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en_i (wr_en),
    .sel_i   (ptype_q),
    .wdata_i (payload_q),
    .data_o  (data_buffer),
    .ctrl_o  (control_buffer),
    .resp_o  (response_buffer),
    .rsvd_o  (reserve_buffer)
  );

endmodule

// File: tb/tb_noc_router.sv
// Self-checking bench for noc_router: directed packets, backpressure, drops,
// back-to-back throughput, async reset mid-delivery and randomized traffic.
module tb_noc_router;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [12:0] packet = '0;
  logic        pack_valid = 1'b0;
  logic        pack_gen_ready = 1'b0;
  logic        nocr_ready;
  logic        nocr_valid;
  logic [7:0]  data_buffer;
  logic [7:0]  control_buffer;
  logic [7:0]  response_buffer;
  logic [7:0]  reserve_buffer;
`ifdef ADDR_FILTER_EN
  logic [7:0]  drop_count;
`endif

  int checks = 0;
  int passed = 0;

  logic [7:0] exp_buf [4];
  int         drop_exp = 0;

  always #5 clk = ~clk;

  noc_router dut (
    .clk             (clk),
    .reset           (reset),
    .packet          (packet),
    .pack_valid      (pack_valid),
    .nocr_ready      (nocr_ready),
    .nocr_valid      (nocr_valid),
    .pack_gen_ready  (pack_gen_ready),
    .data_buffer     (data_buffer),
    .control_buffer  (control_buffer),
    .response_buffer (response_buffer),
    .reserve_buffer  (reserve_buffer)
`ifdef ADDR_FILTER_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  // Reference rule: a packet is delivered iff hdr_valid is set (and, with filtering, addr matches node 0).
  function automatic bit mdl_delivers(input logic [12:0] p);
`ifdef ADDR_FILTER_EN
    return p[12] && (p[1:0] == 2'b00);
`else
    return p[12];
`endif
  endfunction

  function automatic logic [31:0] exp_bufs();
    return {exp_buf[0], exp_buf[1], exp_buf[2], exp_buf[3]};
  endfunction

  function automatic logic [31:0] got_bufs();
    return {data_buffer, control_buffer, response_buffer, reserve_buffer};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) exp_buf[i] = 8'h00;
    drop_exp = 0;
  endtask

  task automatic test_reset();
    model_clear();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({nocr_ready, nocr_valid} !== 2'b00)
      $display("FAIL reset_hold_hs ready/valid=%b required 00", {nocr_ready, nocr_valid});
    else passed++;
    checks++;
    if (got_bufs() !== 32'h0)
      $display("FAIL reset_hold_bufs got=%h required %h", got_bufs(), 32'h0);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({nocr_ready, nocr_valid} !== 2'b10)
      $display("FAIL reset_idle_hs ready/valid=%b required 10", {nocr_ready, nocr_valid});
    else passed++;
    checks++;
    if (got_bufs() !== 32'h0)
      $display("FAIL reset_idle_bufs got=%h required %h", got_bufs(), 32'h0);
    else passed++;
`ifdef ADDR_FILTER_EN
    checks++;
    if (drop_count !== 8'h00)
      $display("FAIL reset_drop_count got=%h required 00", drop_count);
    else passed++;
`endif
    $display("reset released: ready=%b valid=%b", nocr_ready, nocr_valid);
  endtask

  // One full packet transaction; hold = number of edges pack_gen_ready stays low in DELIVER.
  task automatic test_packet(input logic [12:0] p, input int hold);
    bit dlv;
    int waited;
    waited = 0;
    while (nocr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (nocr_ready !== 1'b1)
      $display("FAIL idle_ready pkt=%h ready=%b required 1", p, nocr_ready);
    else passed++;

    dlv = mdl_delivers(p);
    packet = p;
    pack_valid = 1'b1;
    pack_gen_ready = (hold == 0);
    @(negedge clk);
    pack_valid = 1'b0;
    packet = 13'($urandom);

    checks++;
    if ({nocr_ready, nocr_valid} !== 2'b00)
      $display("FAIL route_hs pkt=%h ready/valid=%b required 00", p, {nocr_ready, nocr_valid});
    else passed++;
    checks++;
    if (got_bufs() !== exp_bufs())
      $display("FAIL route_bufs pkt=%h got=%h required %h", p, got_bufs(), exp_bufs());
    else passed++;

    if (dlv) exp_buf[p[3:2]] = p[11:4];
    else if (drop_exp < 255) drop_exp++;

    @(negedge clk);
    if (dlv) begin
      checks++;
      if ({nocr_valid, nocr_ready} !== 2'b10)
        $display("FAIL deliver_hs pkt=%h valid/ready=%b required 10", p, {nocr_valid, nocr_ready});
      else passed++;
      checks++;
      if (got_bufs() !== exp_bufs())
        $display("FAIL deliver_bufs pkt=%h got=%h required %h", p, got_bufs(), exp_bufs());
      else passed++;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        checks++;
        if ({nocr_valid, nocr_ready} !== 2'b10)
          $display("FAIL deliver_hold pkt=%h cyc=%0d valid/ready=%b required 10",
                   p, i, {nocr_valid, nocr_ready});
        else passed++;
      end
      pack_gen_ready = 1'b1;
      @(negedge clk);
      pack_gen_ready = 1'b0;
    end
    checks++;
    if ({nocr_valid, nocr_ready} !== 2'b01)
      $display("FAIL back_to_idle pkt=%h valid/ready=%b required 01", p, {nocr_valid, nocr_ready});
    else passed++;
    checks++;
    if (got_bufs() !== exp_bufs())
      $display("FAIL final_bufs pkt=%h got=%h required %h", p, got_bufs(), exp_bufs());
    else passed++;
`ifdef ADDR_FILTER_EN
    checks++;
    if (drop_count !== 8'(drop_exp))
      $display("FAIL drop_count pkt=%h got=%0d required %0d", p, drop_count, drop_exp);
    else passed++;
`endif
    $display("pkt %h type=%0d payload=%h deliver=%0d hold=%0d", p, p[3:2], p[11:4], dlv, hold);
  endtask

  task automatic test_directed();
    test_packet(13'h1A51, 0);
    test_packet(13'h13C6, 0);
    test_packet(13'h1FFB, 0);
    test_packet(13'h100C, 0);
  endtask

  task automatic test_backpressure();
    test_packet(13'h1770, 5);
  endtask

  task automatic test_drop();
    test_packet(13'h0A51, 0);
    test_packet(13'h0FFF, 2);
  endtask

  // pack_valid held high with pack_gen_ready high: one delivery every 3 cycles.
  task automatic test_back_to_back();
    logic [12:0] p;
    int vcount;
    p = {1'b1, 8'h69, 2'b01, 2'b00};
    vcount = 0;
    while (nocr_ready !== 1'b1 && vcount < 20) begin
      @(negedge clk);
      vcount++;
    end
    vcount = 0;
    packet = p;
    pack_valid = 1'b1;
    pack_gen_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (nocr_valid === 1'b1) vcount++;
    end
    pack_valid = 1'b0;
    pack_gen_ready = 1'b0;
    exp_buf[p[3:2]] = p[11:4];
    checks++;
    if (vcount !== 3)
      $display("FAIL b2b_deliveries got=%0d required 3", vcount);
    else passed++;
    checks++;
    if ({nocr_valid, nocr_ready} !== 2'b01)
      $display("FAIL b2b_end_idle valid/ready=%b required 01", {nocr_valid, nocr_ready});
    else passed++;
    checks++;
    if (got_bufs() !== exp_bufs())
      $display("FAIL b2b_bufs got=%h required %h", got_bufs(), exp_bufs());
    else passed++;
    $display("back-to-back pkt %h deliveries=%0d in 9 cycles", p, vcount);
  endtask

  task automatic test_reset_mid_deliver();
    int waited;
    waited = 0;
    while (nocr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    packet = {1'b1, 8'h5A, 2'b10, 2'b00};
    pack_valid = 1'b1;
    pack_gen_ready = 1'b0;
    @(negedge clk);
    pack_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (nocr_valid !== 1'b1)
      $display("FAIL mid_reset_setup valid=%b required 1", nocr_valid);
    else passed++;
    #2 reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({nocr_valid, nocr_ready} !== 2'b00)
      $display("FAIL mid_reset_hs valid/ready=%b required 00", {nocr_valid, nocr_ready});
    else passed++;
    checks++;
    if (got_bufs() !== exp_bufs())
      $display("FAIL mid_reset_bufs got=%h required %h", got_bufs(), exp_bufs());
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({nocr_valid, nocr_ready} !== 2'b01)
      $display("FAIL mid_reset_release valid/ready=%b required 01", {nocr_valid, nocr_ready});
    else passed++;
    $display("async reset during DELIVER: valid=%b bufs=%h", nocr_valid, got_bufs());
  endtask

  task automatic test_random();
    logic [12:0] p;
    for (int n = 0; n < 30; n++) begin
      p = 13'($urandom);
      p[12] = ($urandom_range(0, 3) != 0);
      test_packet(p, $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid_deliver();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
